// File: rtl/clock_control_if.sv
// Board-facing signal bundle for the run/step clock controller: raw buttons,
// switch, CPU halt level and divider feedback in, divider controls and
// status out.
interface clock_control_if;
    logic        btn_run;
    logic        btn_step;
    logic        sw_fast;
    logic        cpu_halt;
    logic        slow_clk;
    logic        halt;
    logic        set_freq;
    logic [1:0]  state;
    logic [15:0] step_count;

    // Board / stimulus side: drives the raw inputs, observes the controls.
    modport master (
        output btn_run, btn_step, sw_fast, cpu_halt, slow_clk,
        input  halt, set_freq, state, step_count
    );

    // Controller side.
    modport slave (
        input  btn_run, btn_step, sw_fast, cpu_halt, slow_clk,
        output halt, set_freq, state, step_count
    );
endinterface

// File: rtl/clock_control.sv
// Run/step controller upstream of the CPU clock divider. It debounces the run
// and step buttons and the fast switch, and watches the divider's slow clock.
// It drives the divider halt/set_freq so the CPU free-runs, pauses, advances
// exactly one slow period per step press, or latches a CPU halt.
module clock_control #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic            clk,
    input  logic            reset,
    clock_control_if.slave  bus
);
    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    // The counter only has to reach DEBOUNCE_CYCLES-1: the accepting cycle is
    // the one in which it would reach DEBOUNCE_CYCLES.
    localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit 0 = run button, bit 1 = step button, bit 2 = fast switch.
    logic [2:0]       w_raw;
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_stable;
    logic [CNT_W-1:0] r_cnt [3];
    logic [1:0]       r_btn_prev;

    logic             r_slow_s1;
    logic             r_slow_s2;
    logic             r_slow_prev;

    logic             w_run_press;
    logic             w_step_press;
    logic             w_slow_rise;

    state_t           r_state;
    logic [15:0]      r_step_count;

    assign w_raw = {bus.sw_fast, bus.btn_step, bus.btn_run};

    // Two-flop synchronisers for the asynchronous board inputs and slow clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_slow_s1 <= 1'b0;
            r_slow_s2 <= 1'b0;
        end else begin
            r_sync1   <= w_raw;
            r_sync2   <= r_sync1;
            r_slow_s1 <= bus.slow_clk;
            r_slow_s2 <= r_slow_s1;
        end
    end

    // Debounce: accept a new level only after it has differed from the stable
    // level for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable <= '0;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] != r_stable[i]) begin
                    if (r_cnt[i] == CNT_LAST) begin
                        r_stable[i] <= r_sync2[i];
                        r_cnt[i]    <= '0;
                    end else begin
                        r_cnt[i]    <= r_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    // Edge history for button press detection and slow-clock rise detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_prev  <= '0;
            r_slow_prev <= 1'b0;
        end else begin
            r_btn_prev  <= r_stable[1:0];
            r_slow_prev <= r_slow_s2;
        end
    end

    assign w_run_press  = r_stable[0] & ~r_btn_prev[0];
    assign w_step_press = r_stable[1] & ~r_btn_prev[1];
    assign w_slow_rise  = r_slow_s2 & ~r_slow_prev;

    // Run/step state machine; a CPU halt always wins and HALTED is terminal.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= PAUSED;
        end else begin
            case (r_state)
                PAUSED: begin
                    if (bus.cpu_halt)       r_state <= HALTED;
                    else if (w_run_press)   r_state <= RUN;
                    else if (w_step_press)  r_state <= STEP;
                end
                RUN: begin
                    if (bus.cpu_halt)       r_state <= HALTED;
                    else if (w_run_press)   r_state <= PAUSED;
                end
                STEP: begin
                    if (bus.cpu_halt)       r_state <= HALTED;
                    else if (w_slow_rise)   r_state <= PAUSED;
                end
                HALTED: begin
                    r_state <= HALTED;
                end
                default: begin
                    r_state <= PAUSED;
                end
            endcase
        end
    end

    // Count slow-clock rises let through while the divider is running,
    // including the rise that ends a single step.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_step_count <= 16'd0;
        end else if (w_slow_rise && (r_state == RUN || r_state == STEP)) begin
            r_step_count <= r_step_count + 16'd1;
        end
    end

    // The divider halt is a pure decode of the state register.
    assign bus.halt       = (r_state == PAUSED) || (r_state == HALTED);
    assign bus.set_freq   = r_stable[2];
    assign bus.state      = r_state;
    assign bus.step_count = r_step_count;

endmodule

// File: tb/tb_clock_control.sv
// Self-checking bench for clock_control with DEBOUNCE_CYCLES = 4.
// Inputs are changed 1 ns after a rising edge N. A button therefore changes
// state at edge N+7, the switch reaches set_freq at N+6, a slow_clk rise is
// seen at N+3 and cpu_halt acts at N+1.
module tb_clock_control;
    localparam int D = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    clock_control_if bus ();

    clock_control #(.DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: expected state (0..3), step count and set_freq.
    int m_state;
    int m_count;
    int m_freq;

    // Transition table for the controller.
    function automatic int ref_next(input int st, input bit run_p, input bit step_p,
                                    input bit halt_in, input bit rise);
        int nx;
        nx = st;
        if (st == 0) begin
            if (halt_in)     nx = 3;
            else if (run_p)  nx = 1;
            else if (step_p) nx = 2;
        end else if (st == 1) begin
            if (halt_in)     nx = 3;
            else if (run_p)  nx = 0;
        end else if (st == 2) begin
            if (halt_in)     nx = 3;
            else if (rise)   nx = 0;
        end
        return nx;
    endfunction

    function automatic bit ref_halt(input int st);
        return (st == 0) || (st == 3);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive n slow_clk pulses with random high/low widths.
    task automatic slow_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            bus.slow_clk = 1'b1;
            tick($urandom_range(1, 3));
            bus.slow_clk = 1'b0;
            tick($urandom_range(1, 3));
        end
    endtask

    task automatic test_reset;
        bus.btn_run  = 1'b0;
        bus.btn_step = 1'b0;
        bus.sw_fast  = 1'b0;
        bus.cpu_halt = 1'b0;
        bus.slow_clk = 1'b0;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        m_state = 0;
        m_count = 0;
        m_freq  = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            n_vec++;
            if (bus.state !== 2'd0 || bus.halt !== 1'b1 || bus.set_freq !== 1'b0 ||
                bus.step_count !== 16'd0) begin
                n_miss++;
                $display("FAIL reset_idle cycle %0d: state=%0d halt=%b set_freq=%b count=%0d, expected 0/1/0/0",
                         i, bus.state, bus.halt, bus.set_freq, bus.step_count);
            end
        end
    endtask

    task automatic test_run_press;
        for (int p = 0; p < 2; p++) begin
            bus.btn_run = 1'b1;
            tick(6);
            n_vec++;
            if (bus.state !== 2'(m_state)) begin
                n_miss++;
                $display("FAIL run_press_early %0d: state=%0d, expected %0d", p, bus.state, m_state);
            end
            m_state = ref_next(m_state, 1'b1, 1'b0, 1'b0, 1'b0);
            tick(1);
            n_vec++;
            if (bus.state !== 2'(m_state) || bus.halt !== ref_halt(m_state)) begin
                n_miss++;
                $display("FAIL run_press %0d: state=%0d halt=%b, expected %0d/%b",
                         p, bus.state, bus.halt, m_state, ref_halt(m_state));
            end
            tick($urandom_range(1, 6));
            bus.btn_run = 1'b0;
            tick(10);
            n_vec++;
            if (bus.state !== 2'(m_state)) begin
                n_miss++;
                $display("FAIL run_release %0d: state=%0d, expected %0d", p, bus.state, m_state);
            end
        end
    endtask

    task automatic test_step_bounce;
        int per;
        per = $urandom_range(1, 3);
        for (int i = 0; i < 20; i++) begin
            bus.btn_step = ((i / per) % 2) == 0;
            tick(1);
            n_vec++;
            if (bus.state !== 2'(m_state)) begin
                n_miss++;
                $display("FAIL step_bounce cycle %0d period %0d: state=%0d, expected %0d",
                         i, per, bus.state, m_state);
            end
        end
        bus.btn_step = 1'b0;
        tick(8);
        n_vec++;
        if (bus.state !== 2'(m_state)) begin
            n_miss++;
            $display("FAIL step_bounce_settle: state=%0d, expected %0d", bus.state, m_state);
        end
        // Clean step press.
        bus.btn_step = 1'b1;
        tick(6);
        n_vec++;
        if (bus.state !== 2'(m_state)) begin
            n_miss++;
            $display("FAIL step_press_early: state=%0d, expected %0d", bus.state, m_state);
        end
        m_state = ref_next(m_state, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1);
        n_vec++;
        if (bus.state !== 2'(m_state) || bus.halt !== ref_halt(m_state)) begin
            n_miss++;
            $display("FAIL step_press: state=%0d halt=%b, expected %0d/%b",
                     bus.state, bus.halt, m_state, ref_halt(m_state));
        end
        bus.btn_step = 1'b0;
        tick($urandom_range(2, 5));
        // One slow rise ends the step three edges later.
        bus.slow_clk = 1'b1;
        tick(2);
        n_vec++;
        if (bus.state !== 2'(m_state) || bus.step_count !== 16'(m_count)) begin
            n_miss++;
            $display("FAIL step_rise_early: state=%0d count=%0d, expected %0d/%0d",
                     bus.state, bus.step_count, m_state, m_count);
        end
        m_count = m_count + 1;
        m_state = ref_next(m_state, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1);
        n_vec++;
        if (bus.state !== 2'(m_state) || bus.step_count !== 16'(m_count) ||
            bus.halt !== ref_halt(m_state)) begin
            n_miss++;
            $display("FAIL step_rise: state=%0d count=%0d halt=%b, expected %0d/%0d/%b",
                     bus.state, bus.step_count, bus.halt, m_state, m_count, ref_halt(m_state));
        end
        bus.slow_clk = 1'b0;
        tick(10);
    endtask

    task automatic test_run_count;
        int n;
        bus.btn_run = 1'b1;
        tick(7);
        m_state = ref_next(m_state, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (bus.state !== 2'(m_state)) begin
            n_miss++;
            $display("FAIL count_enter_run: state=%0d, expected %0d", bus.state, m_state);
        end
        bus.btn_run = 1'b0;
        tick(8);
        n = 5 + $urandom_range(0, 3);
        slow_pulses(n);
        m_count = (m_count + n) % 65536;
        tick(4);
        n_vec++;
        if (bus.step_count !== 16'(m_count)) begin
            n_miss++;
            $display("FAIL run_count n=%0d: count=%0d, expected %0d", n, bus.step_count, m_count);
        end
        // Jump the counter close to its top instead of driving 65k pulses.
        force dut.r_step_count = 16'hFFFD;
        tick(1);
        release dut.r_step_count;
        m_count = 16'hFFFD;
        tick(2);
        n = $urandom_range(3, 6);
        slow_pulses(n);
        m_count = (m_count + n) % 65536;
        tick(4);
        n_vec++;
        if (bus.step_count !== 16'(m_count)) begin
            n_miss++;
            $display("FAIL count_wrap n=%0d: count=%0d, expected %0d", n, bus.step_count, m_count);
        end
    endtask

    task automatic test_halt;
        bus.cpu_halt = 1'b1;
        tick(1);
        bus.cpu_halt = 1'b0;
        m_state = ref_next(m_state, 1'b0, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (bus.state !== 2'(m_state) || bus.halt !== ref_halt(m_state)) begin
            n_miss++;
            $display("FAIL halt_enter: state=%0d halt=%b, expected %0d/%b",
                     bus.state, bus.halt, m_state, ref_halt(m_state));
        end
        slow_pulses(2);
        tick(4);
        n_vec++;
        if (bus.step_count !== 16'(m_count)) begin
            n_miss++;
            $display("FAIL halt_no_count: count=%0d, expected %0d", bus.step_count, m_count);
        end
        bus.btn_run = 1'b1;
        tick(7);
        m_state = ref_next(m_state, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (bus.state !== 2'(m_state)) begin
            n_miss++;
            $display("FAIL halt_sticky: state=%0d, expected %0d", bus.state, m_state);
        end
        bus.btn_run = 1'b0;
        tick(8);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        m_state = 0;
        m_count = 0;
        n_vec++;
        if (bus.state !== 2'd0 || bus.halt !== 1'b1 || bus.step_count !== 16'd0) begin
            n_miss++;
            $display("FAIL halt_reset: state=%0d halt=%b count=%0d, expected 0/1/0",
                     bus.state, bus.halt, bus.step_count);
        end
        tick(2);
    endtask

    task automatic test_step_halt;
        bus.btn_step = 1'b1;
        tick(7);
        m_state = ref_next(m_state, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.btn_step = 1'b0;
        tick(3);
        // Slow rise and cpu_halt land on the same edge.
        bus.slow_clk = 1'b1;
        tick(2);
        bus.cpu_halt = 1'b1;
        tick(1);
        bus.cpu_halt = 1'b0;
        m_count = m_count + 1;
        m_state = ref_next(m_state, 1'b0, 1'b0, 1'b1, 1'b1);
        n_vec++;
        if (bus.state !== 2'(m_state) || bus.step_count !== 16'(m_count) ||
            bus.halt !== ref_halt(m_state)) begin
            n_miss++;
            $display("FAIL step_halt: state=%0d count=%0d halt=%b, expected %0d/%0d/%b",
                     bus.state, bus.step_count, bus.halt, m_state, m_count, ref_halt(m_state));
        end
        bus.slow_clk = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        m_state = 0;
        m_count = 0;
        tick(2);
    endtask

    task automatic test_back_to_back;
        int n;
        // Run and step pressed together from PAUSED: run wins.
        bus.btn_run  = 1'b1;
        bus.btn_step = 1'b1;
        tick(7);
        m_state = ref_next(m_state, 1'b1, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (bus.state !== 2'(m_state)) begin
            n_miss++;
            $display("FAIL both_press: state=%0d, expected %0d", bus.state, m_state);
        end
        bus.btn_run  = 1'b0;
        bus.btn_step = 1'b0;
        tick(8);
        // Step press ignored in RUN.
        bus.btn_step = 1'b1;
        tick(7);
        m_state = ref_next(m_state, 1'b0, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (bus.state !== 2'(m_state)) begin
            n_miss++;
            $display("FAIL step_in_run: state=%0d, expected %0d", bus.state, m_state);
        end
        bus.btn_step = 1'b0;
        tick(8);
        n = $urandom_range(1, 4);
        slow_pulses(n);
        m_count = m_count + n;
        tick(4);
        // Back to PAUSED; pulses there are not counted.
        bus.btn_run = 1'b1;
        tick(7);
        m_state = ref_next(m_state, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.btn_run = 1'b0;
        slow_pulses($urandom_range(1, 4));
        tick(4);
        n_vec++;
        if (bus.state !== 2'(m_state) || bus.step_count !== 16'(m_count) ||
            bus.halt !== ref_halt(m_state)) begin
            n_miss++;
            $display("FAIL paused_no_count: state=%0d count=%0d halt=%b, expected %0d/%0d/%b",
                     bus.state, bus.step_count, bus.halt, m_state, m_count, ref_halt(m_state));
        end
        tick(8);
    endtask

    task automatic test_fast_switch;
        int g;
        g = $urandom_range(1, 3);
        bus.sw_fast = 1'b1;
        tick(g);
        bus.sw_fast = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            n_vec++;
            if (bus.set_freq !== 1'(m_freq)) begin
                n_miss++;
                $display("FAIL fast_glitch len %0d cycle %0d: set_freq=%b, expected %0d",
                         g, i, bus.set_freq, m_freq);
            end
        end
        bus.sw_fast = 1'b1;
        tick(5);
        n_vec++;
        if (bus.set_freq !== 1'(m_freq)) begin
            n_miss++;
            $display("FAIL fast_early: set_freq=%b, expected %0d", bus.set_freq, m_freq);
        end
        m_freq = 1;
        tick(1);
        n_vec++;
        if (bus.set_freq !== 1'(m_freq)) begin
            n_miss++;
            $display("FAIL fast_set: set_freq=%b, expected %0d", bus.set_freq, m_freq);
        end
        // Release the switch and reset in the middle of its debounce.
        bus.sw_fast = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        m_freq  = 0;
        m_state = 0;
        m_count = 0;
        n_vec++;
        if (bus.set_freq !== 1'b0 || bus.state !== 2'd0 || bus.step_count !== 16'd0) begin
            n_miss++;
            $display("FAIL fast_reset: set_freq=%b state=%0d count=%0d, expected 0/0/0",
                     bus.set_freq, bus.state, bus.step_count);
        end
        tick(4);
        // Reset mid-count discards progress: the full latency starts again.
        bus.sw_fast = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(5);
        n_vec++;
        if (bus.set_freq !== 1'b0) begin
            n_miss++;
            $display("FAIL fast_restart_early: set_freq=%b, expected 0", bus.set_freq);
        end
        m_freq = 1;
        tick(1);
        n_vec++;
        if (bus.set_freq !== 1'(m_freq)) begin
            n_miss++;
            $display("FAIL fast_restart: set_freq=%b, expected %0d", bus.set_freq, m_freq);
        end
    endtask

    initial begin
        test_reset();
        test_run_press();
        test_step_bounce();
        test_run_count();
        test_halt();
        test_step_halt();
        test_back_to_back();
        test_fast_switch();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
